serial_transfer_ctrl: RTL and testbench

SERIAL_TRANSFER_CTRL -- requirements
Module: serial_transfer_ctrl

---
 rtl/serial_ctrl_pkg.sv | 12 +
 rtl/shift_register.sv | 36 +++
 rtl/serial_transfer_ctrl.sv | 87 ++++++++
 tb/tb_serial_transfer_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_ctrl_pkg.sv
// Shared types and defaults for the serial transfer controller.
package serial_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_register.sv
// Parallel-load, right-shift register; vacated MSB fills with 1 so the line idles high.
module shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH == 1) begin : g_single
      assign shifted = 1'b1;
    end else begin : g_multi
      assign shifted = {1'b1, q_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '1;
    end else if (load) begin
      q_reg <= d;
    end else if (shift) begin
      q_reg <= shifted;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/serial_transfer_ctrl.sv
// LSB-first serialiser: IDLE/SHIFT/DONE FSM with bit counter driving a shift register.
module serial_transfer_ctrl
  import serial_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    shift      = 1'b0;
    case (state_reg)
      IDLE: begin
        // start wins over a simultaneous abort here
        if (start) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          shift = 1'b1;
          if (cnt_reg == LAST) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  shift_register #(
    .WIDTH(WIDTH)
  ) u_shift_register (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .shift(shift),
    .d    (data_in),
    .q    (q)
  );

  assign serial_out = (state_reg == SHIFT) ? q[0] : 1'b1;
  assign busy       = (state_reg == SHIFT);
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_serial_transfer_ctrl.sv
// Directed bench for serial_transfer_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_transfer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] data_in;
  logic       serial_out, busy, done;

  logic       start1, abort1;
  logic [0:0] data1;
  logic       ser1, busy1, done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_transfer_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .data_in(data_in), .serial_out(serial_out), .busy(busy), .done(done)
  );

  serial_transfer_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .data_in(data1), .serial_out(ser1), .busy(busy1), .done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called in cycle 1 of a transfer; returns in cycle WIDTH+1 (the DONE cycle).
  task automatic check_bits(input string tag, input logic [7:0] word);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), serial_out, word[i]);
      chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
      chk($sformatf("%s_nodone%0d", tag, i), done, 1'b0);
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ser"}, serial_out, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; data_in = 8'h00;
    start1 = 1'b1; abort1 = 1'b0; data1 = 1'b0;
    step(); step();
    check_idle("reset");
    chk("reset_ser1", ser1, 1'b1);
    chk("reset_busy1", busy1, 1'b0);
    chk("reset_done1", done1, 1'b0);
    start = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    step();
    check_idle("post_reset");

    // Basic transfer 0xA5
    data_in = 8'hA5; start = 1'b1;
    step();
    start = 1'b0; data_in = 8'h00;
    check_bits("a5", 8'hA5);
    chk("a5_done", done, 1'b1);
    chk("a5_done_busy", busy, 1'b0);
    chk("a5_done_ser", serial_out, 1'b1);
    $display("txn basic 0xA5 checked");
    step();
    check_idle("a5_after");

    // start held while busy, data changed after acceptance
    data_in = 8'h3C; start = 1'b1;
    step();
    data_in = 8'hFF;
    check_bits("3c", 8'h3C);
    chk("3c_done", done, 1'b1);
    data_in = 8'hFE;
    step();
    check_idle("3c_gap");
    step();
    chk("3c_second_busy", busy, 1'b1);
    chk("3c_second_bit0", serial_out, 1'b0);
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("3c_cleanup");
    $display("txn start-while-busy 0x3C checked");

    // Abort in cycle 3 of 0x0F
    data_in = 8'h0F; start = 1'b1;
    step();
    start = 1'b0;
    chk("ab_bit0", serial_out, 1'b1);
    step();
    chk("ab_bit1", serial_out, 1'b1);
    step();
    chk("ab_bit2", serial_out, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("ab_c4");
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("ab_nodone%0d", i), done, 1'b0);
    end
    $display("txn abort 0x0F checked");

    // Reset in cycle 5 with start asserted
    data_in = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rs_bit%0d", i), serial_out, i[0] ? 1'b0 : 1'b1);
      step();
    end
    chk("rs_busy_c5", busy, 1'b1);
    rst_n = 1'b0; start = 1'b1;
    step();
    check_idle("rs_c6");
    rst_n = 1'b1; start = 1'b0;
    step();
    check_idle("rs_c7");
    $display("txn reset mid-shift checked");

    // start and abort together in IDLE
    data_in = 8'h81; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_bits("81", 8'h81);
    chk("81_done", done, 1'b1);
    step();
    check_idle("81_after");
    $display("txn start+abort 0x81 checked");

    // WIDTH=1 edge case
    data1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0; data1 = 1'b1;
    chk("w1_ser_c1", ser1, 1'b0);
    chk("w1_busy_c1", busy1, 1'b1);
    chk("w1_done_c1", done1, 1'b0);
    step();
    chk("w1_done_c2", done1, 1'b1);
    chk("w1_busy_c2", busy1, 1'b0);
    chk("w1_ser_c2", ser1, 1'b1);
    step();
    chk("w1_done_c3", done1, 1'b0);
    chk("w1_ser_c3", ser1, 1'b1);
    $display("txn width1 data 0 checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
